// File: rtl/uart_frame_ctrl_if.sv
// Bundle of the receive-byte, RAM-write and reader-handshake signals of the frame controller.
// The controller connects through slave; the environment connects through master.
interface uart_frame_ctrl_if #(
  parameter int unsigned ADDR_W = 7
);
  logic [7:0]      rx_byte;
  logic            rx_valid;
  logic            wr_en;
  logic [ADDR_W:0] wr_addr;
  logic [7:0]      wr_data;
  logic            frame_ready;
  logic            frame_bank;
  logic            frame_ack;
  logic            err_timeout;
  logic            err_overrun;
  logic [15:0]     frame_cnt;

  modport master (
    output rx_byte, rx_valid, frame_ack,
    input  wr_en, wr_addr, wr_data, frame_ready, frame_bank,
           err_timeout, err_overrun, frame_cnt
  );

  modport slave (
    input  rx_byte, rx_valid, frame_ack,
    output wr_en, wr_addr, wr_data, frame_ready, frame_bank,
           err_timeout, err_overrun, frame_cnt
  );
endinterface

// File: rtl/uart_frame_ctrl.sv
// Frame controller: hunts for a sync byte, stores the payload into a ping-pong RAM bank,
// and hands each completed bank to the reader with a ready/ack handshake.
module uart_frame_ctrl #(
  parameter int unsigned FRAME_LEN = 113,
  parameter int unsigned ADDR_W    = 7,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [15:0] TIMEOUT   = 16'd50000
) (
  input logic              clk_Rx,
  input logic              rst,
  uart_frame_ctrl_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(FRAME_LEN - 1);
  localparam logic [16:0]       TMO_LIMIT = {1'b0, TIMEOUT};

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t            state;
  logic              wr_bank;
  logic              rd_bank;
  logic [1:0]        full;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       tmo;

  logic [1:0]        full_nxt;
  logic              rd_nxt;
  logic              tmo_hit;
  logic              sync_seen;

  // Abort is decided one cycle early so the registered pulse lands TIMEOUT cycles after the last byte.
  assign tmo_hit   = (17'(tmo) + 17'd2) >= TMO_LIMIT;
  assign sync_seen = bus.rx_valid && (bus.rx_byte == SYNC_BYTE);

  // Bank occupancy: commit and ack always touch different banks, so both may apply in one cycle.
  always_comb begin
    full_nxt = full;
    rd_nxt   = rd_bank;
    if (state == COMMIT) begin
      full_nxt[wr_bank] = 1'b1;
    end
    if (bus.frame_ack && full[rd_bank]) begin
      full_nxt[rd_bank] = 1'b0;
      rd_nxt            = ~rd_bank;
    end
  end

  always_ff @(posedge clk_Rx) begin
    if (rst) begin
      state           <= HUNT;
      wr_bank         <= 1'b0;
      rd_bank         <= 1'b0;
      full            <= 2'b00;
      idx             <= '0;
      tmo             <= '0;
      bus.wr_en       <= 1'b0;
      bus.wr_addr     <= '0;
      bus.wr_data     <= '0;
      bus.frame_ready <= 1'b0;
      bus.frame_bank  <= 1'b0;
      bus.err_timeout <= 1'b0;
      bus.err_overrun <= 1'b0;
      bus.frame_cnt   <= '0;
    end else begin
      bus.wr_en       <= 1'b0;
      bus.err_timeout <= 1'b0;
      bus.err_overrun <= 1'b0;

      full            <= full_nxt;
      rd_bank         <= rd_nxt;
      bus.frame_ready <= full_nxt[rd_nxt];
      bus.frame_bank  <= rd_nxt;

      case (state)
        HUNT: begin
          if (sync_seen) begin
            if (full[wr_bank]) begin
              bus.err_overrun <= 1'b1;
            end else begin
              state <= FILL;
              idx   <= '0;
              tmo   <= '0;
            end
          end
        end

        FILL: begin
          if (bus.rx_valid) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= {wr_bank, idx};
            bus.wr_data <= bus.rx_byte;
            idx         <= idx + 1'b1;
            tmo         <= '0;
            if (idx == LAST_IDX) begin
              state <= COMMIT;
            end
          end else if (tmo_hit) begin
            bus.err_timeout <= 1'b1;
            tmo             <= '0;
            state           <= HUNT;
          end else begin
            tmo <= tmo + 16'd1;
          end
        end

        COMMIT: begin
          wr_bank       <= ~wr_bank;
          bus.frame_cnt <= bus.frame_cnt + 16'd1;
          state         <= HUNT;
        end

        default: begin
          state <= HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed self-checking bench for uart_frame_ctrl with a shortened inter-byte timeout.
module tb_uart_frame_ctrl;

  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned FRAME_LEN = 113;
  localparam int unsigned TMO       = 100;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;
  int   wr_count;
  int   wr_mark;

  uart_frame_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  uart_frame_ctrl #(
    .FRAME_LEN(FRAME_LEN),
    .ADDR_W   (ADDR_W),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT  (16'(TMO))
  ) dut (
    .clk_Rx(clk),
    .rst   (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running count of write strobes, sampled on the edge after they appear.
  always @(posedge clk) begin
    if (rst) wr_count <= 0;
    else if (bus.wr_en === 1'b1) wr_count <= wr_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pay(input int mode, input int i);
    logic [7:0] v;
    if (mode == 0) v = 8'(i);
    else if ((i % 16) == 3) v = 8'hA5;
    else v = 8'(i * 3);
    return v;
  endfunction

  // Called at a negedge; drives one valid cycle and checks the write it should (or should not) cause.
  task automatic send_byte(input logic [7:0] b, input logic exp_wr, input logic [7:0] exp_addr);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("wr_en", 32'(bus.wr_en), 32'(exp_wr));
    if (exp_wr) begin
      chk("wr_addr", 32'(bus.wr_addr), 32'(exp_addr));
      chk("wr_data", 32'(bus.wr_data), 32'(b));
    end
  endtask

  // Sync byte plus a full payload; returns at the negedge of the COMMIT cycle.
  task automatic send_frame(input logic bank, input int mode, input int spacing);
    send_byte(8'hA5, 1'b0, 8'h00);
    for (int i = 0; i < int'(FRAME_LEN); i++) begin
      send_byte(pay(mode, i), 1'b1, {bank, 7'(i)});
      if (i != int'(FRAME_LEN) - 1) repeat (spacing - 1) @(negedge clk);
    end
  endtask

  task automatic pulse_ack();
    bus.frame_ack = 1'b1;
    @(negedge clk);
    bus.frame_ack = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.rx_valid  = 1'b0;
    bus.rx_byte   = 8'h00;
    bus.frame_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en",       32'(bus.wr_en),       0);
    chk("rst_wr_addr",     32'(bus.wr_addr),     0);
    chk("rst_frame_ready", 32'(bus.frame_ready), 0);
    chk("rst_frame_bank",  32'(bus.frame_bank),  0);
    chk("rst_err_timeout", 32'(bus.err_timeout), 0);
    chk("rst_err_overrun", 32'(bus.err_overrun), 0);
    chk("rst_frame_cnt",   32'(bus.frame_cnt),   0);
    rst = 1'b0;
    @(negedge clk);

    // Single frame, 10-cycle byte spacing, into bank 0.
    send_frame(1'b0, 0, 10);
    chk("f1_ready_commit", 32'(bus.frame_ready), 0);
    @(negedge clk);
    chk("f1_ready", 32'(bus.frame_ready), 1);
    chk("f1_bank",  32'(bus.frame_bank),  0);
    chk("f1_cnt",   32'(bus.frame_cnt),   1);
    chk("f1_writes", 32'(wr_count), 113);

    // Second frame fills bank 1; both banks now full.
    send_frame(1'b1, 0, 2);
    @(negedge clk);
    chk("f2_ready", 32'(bus.frame_ready), 1);
    chk("f2_bank",  32'(bus.frame_bank),  0);
    chk("f2_cnt",   32'(bus.frame_cnt),   2);
    chk("f2_writes", 32'(wr_count), 226);

    // Third sync byte is refused.
    send_byte(8'hA5, 1'b0, 8'h00);
    chk("ovr_pulse", 32'(bus.err_overrun), 1);
    send_byte(8'h11, 1'b0, 8'h00);
    chk("ovr_width", 32'(bus.err_overrun), 0);
    send_byte(8'h22, 1'b0, 8'h00);
    @(negedge clk);
    chk("ovr_no_writes", 32'(wr_count), 226);

    pulse_ack();
    chk("ack1_ready", 32'(bus.frame_ready), 1);
    chk("ack1_bank",  32'(bus.frame_bank),  1);
    pulse_ack();
    chk("ack2_ready", 32'(bus.frame_ready), 0);
    chk("ack2_bank",  32'(bus.frame_bank),  0);
    pulse_ack();
    chk("ack3_ignored_ready", 32'(bus.frame_ready), 0);
    chk("ack3_ignored_bank",  32'(bus.frame_bank),  0);

    // Timeout: sync, five bytes, silence.
    send_byte(8'hA5, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i), 1'b1, 8'(i));
    repeat (TMO - 2) @(negedge clk);
    chk("tmo_early", 32'(bus.err_timeout), 0);
    @(negedge clk);
    chk("tmo_pulse", 32'(bus.err_timeout), 1);
    @(negedge clk);
    chk("tmo_width", 32'(bus.err_timeout), 0);
    chk("tmo_cnt",   32'(bus.frame_cnt),   2);
    chk("tmo_ready", 32'(bus.frame_ready), 0);
    send_frame(1'b0, 0, 2);
    @(negedge clk);
    chk("f3_cnt",   32'(bus.frame_cnt),   3);
    chk("f3_ready", 32'(bus.frame_ready), 1);
    chk("f3_bank",  32'(bus.frame_bank),  0);
    pulse_ack();
    chk("f3_ack_ready", 32'(bus.frame_ready), 0);

    // Hunt filtering, then a payload with embedded sync values into bank 1.
    wr_mark = wr_count;
    send_byte(8'h00, 1'b0, 8'h00);
    send_byte(8'h55, 1'b0, 8'h00);
    send_byte(8'hFF, 1'b0, 8'h00);
    @(negedge clk);
    chk("hunt_no_writes", 32'(wr_count - wr_mark), 0);
    send_frame(1'b1, 1, 1);
    @(negedge clk);
    chk("f4_cnt",   32'(bus.frame_cnt),   4);
    chk("f4_ready", 32'(bus.frame_ready), 1);
    chk("f4_bank",  32'(bus.frame_bank),  1);
    pulse_ack();
    chk("f4_ack_ready", 32'(bus.frame_ready), 0);

    // Reset after the 50th payload byte.
    send_byte(8'hA5, 1'b0, 8'h00);
    for (int i = 0; i < 50; i++) send_byte(8'(i), 1'b1, 8'(i));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_wr_en",   32'(bus.wr_en),       0);
    chk("mrst_addr",    32'(bus.wr_addr),     0);
    chk("mrst_data",    32'(bus.wr_data),     0);
    chk("mrst_ready",   32'(bus.frame_ready), 0);
    chk("mrst_bank",    32'(bus.frame_bank),  0);
    chk("mrst_tmo",     32'(bus.err_timeout), 0);
    chk("mrst_ovr",     32'(bus.err_overrun), 0);
    chk("mrst_cnt",     32'(bus.frame_cnt),   0);
    send_frame(1'b0, 0, 1);
    @(negedge clk);
    chk("f5_cnt",   32'(bus.frame_cnt),   1);
    chk("f5_ready", 32'(bus.frame_ready), 1);
    chk("f5_bank",  32'(bus.frame_bank),  0);

    // Ack of bank 0 in the same cycle as COMMIT of bank 1.
    send_frame(1'b1, 1, 1);
    chk("sim_pre_ready", 32'(bus.frame_ready), 1);
    chk("sim_pre_bank",  32'(bus.frame_bank),  0);
    pulse_ack();
    chk("sim_ready", 32'(bus.frame_ready), 1);
    chk("sim_bank",  32'(bus.frame_bank),  1);
    chk("sim_cnt",   32'(bus.frame_cnt),   2);
    pulse_ack();
    chk("sim_bank0_clear_ready", 32'(bus.frame_ready), 0);
    chk("sim_bank0_clear_bank",  32'(bus.frame_bank),  0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
# uart_frame_ctrl

Frame controller sitting between the UART receiver and the frame buffer RAM. It hunts for a sync byte, writes the following FRAME_LEN payload bytes into one of two RAM banks (ping-pong), and hands each completed frame to the downstream reader with a ready/ack handshake. It aborts stalled frames on an inter-byte timeout and refuses new frames while both banks are occupied.

## Interface

- FRAME_LEN, 113: payload bytes per frame, excluding the sync byte; range 1..2^ADDR_W.
- ADDR_W, 7: in-bank address width.
- SYNC_BYTE, 8'hA5: frame start marker; not stored.
- TIMEOUT, 16'd50000: maximum idle clk_Rx cycles between payload bytes; range 1..65535.

- clk_Rx  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_byte  in  8  received byte; valid only while rx_valid is high.
- rx_valid  in  1  one-cycle strobe per received byte.
- wr_en  out  1  RAM write strobe, one cycle per payload byte.
- wr_addr  out  ADDR_W+1  {bank, byte index}.
- wr_data  out  8  RAM write data.
- frame_ready  out  1  level; a complete frame is waiting in bank frame_bank.
- frame_bank  out  1  bank the reader must consume.
- frame_ack  in  1  one-cycle pulse; reader has finished with frame_bank.
- err_timeout  out  1  one-cycle pulse; frame aborted on timeout.
- err_overrun  out  1  one-cycle pulse; sync byte refused because both banks are full.
- frame_cnt  out  16  number of committed frames; wraps from 65535 to 0.

## Operation

- State: wr_bank, rd_bank, full[1:0], idx (ADDR_W bits), tmo (16 bits), and an FSM with states HUNT, FILL, and COMMIT.
- HUNT
  - On rx_valid with rx_byte==SYNC_BYTE and full[wr_bank]==0: go to FILL with idx=0 and tmo=0.
  - On the same condition with full[wr_bank]==1: pulse err_overrun and stay in HUNT.
  - All other bytes are ignored.
- FILL
  - On rx_valid: wr_en=1, wr_addr={wr_bank, idx}, wr_data=rx_byte, idx++, tmo=0.
  - If idx==FRAME_LEN-1 on that byte, go to COMMIT.
  - SYNC_BYTE values inside the payload are stored as data.
  - With no rx_valid, tmo++. When tmo reaches TIMEOUT-1 with no byte, pulse err_timeout and go to HUNT. The bank is left uncommitted, and its partial data is overwritten by the next frame.
- COMMIT (one cycle)
  - full[wr_bank]=1, wr_bank toggles, frame_cnt++, go to HUNT.
  - An rx_valid during COMMIT is ignored.
- Reader side
  - frame_ready = full[rd_bank]; frame_bank = rd_bank.
  - frame_ack while frame_ready: clear full[rd_bank] and toggle rd_bank.
  - frame_ack while !frame_ready is ignored.
- Simultaneous COMMIT and frame_ack: both take effect, because they always address different banks.
- Reset mid-frame: the partial frame is discarded and no error pulse is generated.

## Timing

- Reset values:
  - FSM=HUNT; wr_bank=rd_bank=0; full=2'b00.
  - All outputs are 0: wr_en, wr_addr, wr_data, frame_ready, frame_bank, err_timeout, err_overrun, frame_cnt.
- All outputs are registered.
- Write latency: rx_valid at cycle N gives wr_en/wr_addr/wr_data at cycle N+1.
- Last payload byte at N: COMMIT during N+1; frame_ready and frame_cnt update at N+2.
- Ack latency: frame_ack at N gives frame_ready/frame_bank updated at N+1. If the other bank is full, frame_ready stays high and frame_bank toggles.
- Timeout: the last byte (or the sync byte) at N with no further rx_valid gives err_timeout at N+TIMEOUT, and the FSM is in HUNT from N+TIMEOUT.
- The error pulses are exactly one cycle wide.
- wr_en is never asserted outside FILL, and never to a bank with full==1.

## Test plan

- Single frame: A5 followed by 113 bytes 0x00..0x70 at a 10-cycle spacing.
  - Required: 113 writes to addresses 0..112 with data equal to the byte index.
  - Required: frame_ready=1 with frame_bank=0 two cycles after the last byte; frame_cnt=1.
- Ping-pong: two back-to-back frames without ack.
  - Required: the second frame's writes go to addresses 128..240; full=2'b11.
  - Then a third A5 gives err_overrun=1 and no wr_en.
  - Then ack gives frame_bank=1 with frame_ready still 1. A second ack gives frame_ready=0.
- Timeout: A5, 5 bytes, then silence, with TIMEOUT=100.
  - Required: err_timeout 100 cycles after the 5th byte; frame_cnt unchanged; frame_ready=0.
  - A following full frame is written starting at address 0.
- Hunt filtering: bytes 0x00, 0x55, 0xFF, then A5 plus a frame.
  - Required: no writes before the A5; 0xA5 bytes inside the payload are written as data.
- Reset mid-frame: rst for 1 cycle after the 50th byte.
  - Required: all outputs 0 the next cycle. A new frame starts at address 0 with frame_cnt=1 after completion.
- Simultaneous events: frame_ack in the same cycle as COMMIT of bank 1 while bank 0 is ready.
  - Required: full=2'b10 and frame_bank=1 with frame_ready=1 the next cycle.
